// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  localparam int ZERO_REG   = 0;
  localparam int REG_ADDR_W = 6;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register fields into the hazard controller and its stall/bubble controls out.
interface hazard_ctrl_if #(
  parameter int RegAddrW = 6
);
  logic [RegAddrW-1:0] dec_rs1;
  logic [RegAddrW-1:0] dec_rs2;
  logic                dec_use_rs1;
  logic                dec_use_rs2;
  logic                dec_is_branch;
  logic [RegAddrW-1:0] exe_rd;
  logic                exe_reg_we;
  logic                exe_is_load;
  logic                exe_is_mul;
  logic [RegAddrW-1:0] mem_rd;
  logic                mem_reg_we;
  logic                mem_is_load;
  logic                stall;
  logic                exe_bubble;
  logic                exe_hold;
  logic                mem_bubble;
  logic                mul_busy;

  modport master (
    output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_is_branch,
    output exe_rd, exe_reg_we, exe_is_load, exe_is_mul,
    output mem_rd, mem_reg_we, mem_is_load,
    input  stall, exe_bubble, exe_hold, mem_bubble, mul_busy
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_is_branch,
    input  exe_rd, exe_reg_we, exe_is_load, exe_is_mul,
    input  mem_rd, mem_reg_we, mem_is_load,
    output stall, exe_bubble, exe_hold, mem_bubble, mul_busy
  );
endinterface

// File: rtl/hazard_ctrl_mul_timer.sv
// Multiply sequencer: holds Execute for MulCycles-1 cycles per multiply.
module hazard_mul_timer
  import hazard_pkg::*;
#(
  parameter int MulCycles = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic exe_is_mul,
  output logic hold,
  output logic busy
);

  localparam bit         MultiCycle = (MulCycles > 1);
  localparam logic [3:0] CntInit    = MultiCycle ? 4'(MulCycles - 2) : 4'd0;

  mul_state_e state_r;
  logic [3:0] cnt_r;

  // State and down-counter; exe_is_mul only matters in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (exe_is_mul && MultiCycle) begin
            state_r <= BUSY;
            cnt_r   <= CntInit;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            state_r <= BUSY;
            cnt_r   <= cnt_r - 4'd1;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Hold asserts in the entry cycle itself, so it cannot wait for the state register.
  always_comb begin
    hold = 1'b0;
    busy = 1'b0;
    if (reset) begin
      hold = 1'b0;
      busy = 1'b0;
    end else begin
      case (state_r)
        IDLE:    hold = exe_is_mul && MultiCycle;
        BUSY:    hold = (cnt_r != 4'd0);
        default: hold = 1'b0;
      endcase
      busy = (state_r == BUSY);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-dependency hazard detection and multiply hold for the 5-stage pipeline.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall and bubble counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MulCycles = 4,
  parameter int RegAddrW  = REG_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_bubbles
`endif
);

  localparam logic [RegAddrW-1:0] ZeroAddr = RegAddrW'(ZERO_REG);

  logic hold_s;
  logic busy_s;
  logic exe_writes_s;
  logic mem_writes_s;
  logic rs1_exe_s;
  logic rs2_exe_s;
  logic rs1_mem_s;
  logic h1_s;
  logic h2_s;
  logic h3_s;
  logic hazard_s;

  hazard_mul_timer #(
    .MulCycles (MulCycles)
  ) u_mul_timer (
    .clk        (clk),
    .reset      (reset),
    .exe_is_mul (bus.exe_is_mul),
    .hold       (hold_s),
    .busy       (busy_s)
  );

  // Source/destination matches and the three hazard classes.
  always_comb begin
    exe_writes_s = bus.exe_reg_we && (bus.exe_rd != ZeroAddr);
    mem_writes_s = bus.mem_reg_we && (bus.mem_rd != ZeroAddr);
    rs1_exe_s    = exe_writes_s && (bus.dec_rs1 == bus.exe_rd);
    rs2_exe_s    = exe_writes_s && (bus.dec_rs2 == bus.exe_rd);
    rs1_mem_s    = mem_writes_s && (bus.dec_rs1 == bus.mem_rd);
    h1_s = bus.exe_is_load && ((bus.dec_use_rs1 && rs1_exe_s) || (bus.dec_use_rs2 && rs2_exe_s));
    h2_s = bus.dec_is_branch && rs1_exe_s && !bus.exe_is_load;
    h3_s = bus.dec_is_branch &&
           ((rs1_exe_s && bus.exe_is_load) || (rs1_mem_s && bus.mem_is_load));
    hazard_s = h1_s || h2_s || h3_s;
  end

  // Bubbles are masked during hold so the held Execute instruction survives.
  always_comb begin
    bus.stall      = 1'b0;
    bus.exe_bubble = 1'b0;
    bus.exe_hold   = 1'b0;
    bus.mem_bubble = 1'b0;
    bus.mul_busy   = 1'b0;
    if (reset) begin
      bus.stall      = 1'b0;
      bus.exe_bubble = 1'b0;
    end else begin
      bus.stall      = hold_s || hazard_s;
      bus.exe_bubble = !hold_s && hazard_s;
      bus.exe_hold   = hold_s;
      bus.mem_bubble = hold_s;
      bus.mul_busy   = busy_s;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= 32'd0;
      perf_bubbles      <= 32'd0;
    end else begin
      if (bus.stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end else begin
        perf_stall_cycles <= perf_stall_cycles;
      end
      if ((bus.exe_bubble || bus.mem_bubble) && (perf_bubbles != 32'hFFFF_FFFF)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end else begin
        perf_bubbles <= perf_bubbles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic vs a reference model.
module tb_hazard_ctrl;
  localparam int MUL = 4;

  typedef struct {
    logic        stall;
    logic        exe_bubble;
    logic        exe_hold;
    logic        mem_bubble;
    logic        mul_busy;
    logic [31:0] ps;
    logic [31:0] pb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // reference model state: cycles the current multiply has spent in Execute
  int          mul_age = 0;
  logic [31:0] m_ps = 32'd0;
  logic [31:0] m_pb = 32'd0;
  logic [5:0]  pool [5] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'b100000};

  hazard_ctrl_if #(.RegAddrW(6)) bus ();

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bubbles;
`endif

  hazard_ctrl #(.MulCycles(MUL), .RegAddrW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bubbles      (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs after the edge, push the model's expectation, advance the model.
  task automatic drive(input logic rst, input logic [5:0] rs1, input logic [5:0] rs2,
                       input logic u1, input logic u2, input logic br,
                       input logic [5:0] erd, input logic ewe, input logic eld, input logic emul,
                       input logic [5:0] mrd, input logic mwe, input logic mld);
    exp_t e;
    bit dep_e1, dep_e2, dep_m1, load_use, branch_dep, hold;
    @(posedge clk);
    #1;
    reset = rst;
    bus.dec_rs1 = rs1; bus.dec_rs2 = rs2;
    bus.dec_use_rs1 = u1; bus.dec_use_rs2 = u2; bus.dec_is_branch = br;
    bus.exe_rd = erd; bus.exe_reg_we = ewe; bus.exe_is_load = eld; bus.exe_is_mul = emul;
    bus.mem_rd = mrd; bus.mem_reg_we = mwe; bus.mem_is_load = mld;
    e.ps = m_ps;
    e.pb = m_pb;
    if (rst) begin
      e.stall = 1'b0; e.exe_bubble = 1'b0; e.exe_hold = 1'b0;
      e.mem_bubble = 1'b0; e.mul_busy = 1'b0;
      exp_q.push_back(e);
      mul_age = 0; m_ps = 32'd0; m_pb = 32'd0;
    end else begin
      // a source depends on a producer that really writes a non-zero register
      dep_e1 = ewe && (erd != 6'd0) && (rs1 == erd);
      dep_e2 = ewe && (erd != 6'd0) && (rs2 == erd);
      dep_m1 = mwe && (mrd != 6'd0) && (rs1 == mrd);
      load_use   = eld && ((u1 && dep_e1) || (u2 && dep_e2));
      branch_dep = br && (dep_e1 || (dep_m1 && mld));
      if (mul_age == 0 && emul) mul_age = 1;
      hold = (mul_age > 0) && (mul_age < MUL);
      e.stall      = hold || load_use || branch_dep;
      e.exe_bubble = !hold && (load_use || branch_dep);
      e.exe_hold   = hold;
      e.mem_bubble = hold;
      e.mul_busy   = (mul_age >= 2);
      exp_q.push_back(e);
      if (e.stall) m_ps = m_ps + 32'd1;
      if (e.exe_bubble || e.mem_bubble) m_pb = m_pb + 32'd1;
      if (mul_age != 0) mul_age = (mul_age == MUL) ? 0 : mul_age + 1;
    end
  endtask

  task automatic nop(input logic rst);
    drive(rst, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",      {31'd0, bus.stall},      {31'd0, e.stall});
      chk("exe_bubble", {31'd0, bus.exe_bubble}, {31'd0, e.exe_bubble});
      chk("exe_hold",   {31'd0, bus.exe_hold},   {31'd0, e.exe_hold});
      chk("mem_bubble", {31'd0, bus.mem_bubble}, {31'd0, e.mem_bubble});
      chk("mul_busy",   {31'd0, bus.mul_busy},   {31'd0, e.mul_busy});
`ifdef HAZARD_CTRL_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, e.ps);
      chk("perf_bubbles",      perf_bubbles,      e.pb);
`endif
    end
  end

  initial begin
    int wait_cycles;
    bus.dec_rs1 = 6'd0; bus.dec_rs2 = 6'd0; bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0;
    bus.dec_is_branch = 1'b0; bus.exe_rd = 6'd0; bus.exe_reg_we = 1'b0; bus.exe_is_load = 1'b0;
    bus.exe_is_mul = 1'b0; bus.mem_rd = 6'd0; bus.mem_reg_we = 1'b0; bus.mem_is_load = 1'b0;
    repeat (2) @(posedge clk);
    nop(1'b1);
    nop(1'b0);
    // load r3 then decode reads r3 as rs2; next cycle the bubble sits in Execute
    drive(1'b0, 6'd1, 6'd3, 1'b1, 1'b1, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 6'd1, 6'd3, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1);
    // load to r0 never stalls; load to f0 does
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 6'b100000, 6'd0, 1'b1, 1'b0, 1'b0, 6'b100000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    nop(1'b0);
    // branch on r5 behind an ALU write: one stall
    drive(1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1, 1'b0);
    // branch on r5 behind a load: two stalls
    drive(1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1, 1'b1);
    drive(1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    // fresh counters, then a single multiply, a back-to-back one, then one with a masked load-use
    nop(1'b1);
    for (int i = 0; i < MUL; i++)
      drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < MUL; i++)
      drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    nop(1'b0);
    for (int i = 0; i < MUL + 1; i++)
      drive(1'b0, 6'd3, 6'd0, 1'b1, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
    nop(1'b0);
    // reset during the second BUSY cycle aborts the multiply
    for (int i = 0; i < 2; i++)
      drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    drive(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    nop(1'b0);
    nop(1'b0);
    // randomized traffic over a small register pool so matches are frequent
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            pool[$urandom_range(0, 4)], 1'($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom_range(0, 5) == 0),
            pool[$urandom_range(0, 4)], 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
